// File: rtl/serial_frame_shifter.sv
// Parallel-to-serial frame shifter: loads a WIDTH-bit frame on an accepted start
// and drives it out one bit per cycle, then pulses done for a single cycle.
module serial_frame_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] parIn,
    output logic             serOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

    stateT            state;
    logic [WIDTH-1:0] shiftReg;
    logic [CW-1:0]    bitCount;

    // The bit due out next always sits at the head of the shift register.
    function automatic logic headBit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // The first bit is registered straight from parIn at the accepting edge,
    // so the register keeps only the remaining bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCount <= '0;
            serOut   <= IDLE_BIT;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    serOut <= IDLE_BIT;
                    state  <= IDLE;
                    if (start) begin
                        shiftReg <= advance(parIn);
                        serOut   <= headBit(parIn);
                        busy     <= 1'b1;
                        bitCount <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bitCount == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        serOut <= IDLE_BIT;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        bitCount <= bitCount + CW'(1);
                        serOut   <= headBit(shiftReg);
                        shiftReg <= advance(shiftReg);
                    end
                end
                default: begin
                    state  <= IDLE;
                    serOut <= IDLE_BIT;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Bench for serial_frame_shifter: two configurations driven side by side and
// compared cycle by cycle against a queue of expected (serOut, busy, done) tuples.
module tb_serial_frame_shifter;

    logic       clk;
    logic       rst;
    logic       start, startB;
    logic [7:0] parIn;
    logic [4:0] parInB;
    logic       serOut, busy, done;
    logic       serOutB, busyB, doneB;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic s; logic b; logic d;} expT;
    expT qA[$];
    expT qB[$];
    expT curA, curB;

    serial_frame_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutA (
        .clk(clk), .rst(rst), .start(start), .parIn(parIn),
        .serOut(serOut), .busy(busy), .done(done)
    );

    serial_frame_shifter #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutB (
        .clk(clk), .rst(rst), .start(startB), .parIn(parInB),
        .serOut(serOutB), .busy(busyB), .done(doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fbit(input logic [31:0] d, input int k, input int w, input bit msb);
        return msb ? d[w-1-k] : d[k];
    endfunction

    task automatic checkOutput(input string tag, input logic gs, input logic gb,
                               input logic gd, input expT e);
        checks++;
        assert (gs === e.s) else begin
            errors++;
            $error("[TB] FAIL %s serOut t=%0t got=%b exp=%b", tag, $time, gs, e.s);
        end
        checks++;
        assert (gb === e.b) else begin
            errors++;
            $error("[TB] FAIL %s busy t=%0t got=%b exp=%b", tag, $time, gb, e.b);
        end
        checks++;
        assert (gd === e.d) else begin
            errors++;
            $error("[TB] FAIL %s done t=%0t got=%b exp=%b", tag, $time, gd, e.d);
        end
    endtask

    // A frame is accepted whenever the cycle before the edge was not busy;
    // the accepted frame replaces whatever the model still had pending.
    task automatic applyStimulus(input logic sA, input logic [7:0] pA,
                                 input logic sB, input logic [4:0] pB);
        start  = sA;
        parIn  = pA;
        startB = sB;
        parInB = pB;
        if (sA && !curA.b) begin
            qA.delete();
            for (int k = 0; k < 8; k++) qA.push_back({fbit(32'(pA), k, 8, 1'b1), 1'b1, 1'b0});
            qA.push_back({1'b0, 1'b0, 1'b1});
        end
        if (sB && !curB.b) begin
            qB.delete();
            for (int k = 0; k < 5; k++) qB.push_back({fbit(32'(pB), k, 5, 1'b0), 1'b1, 1'b0});
            qB.push_back({1'b1, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1;
        if (qA.size() > 0) curA = qA.pop_front();
        else               curA = {1'b0, 1'b0, 1'b0};
        if (qB.size() > 0) curB = qB.pop_front();
        else               curB = {1'b1, 1'b0, 1'b0};
        checkOutput("A", serOut, busy, done, curA);
        checkOutput("B", serOutB, busyB, doneB, curB);
    endtask

    initial begin
        logic [7:0] gotA;
        logic [4:0] gotB;
        rst    = 1'b0;
        start  = 1'b0;
        startB = 1'b0;
        parIn  = '0;
        parInB = '0;
        curA   = {1'b0, 1'b0, 1'b0};
        curB   = {1'b1, 1'b0, 1'b0};

        // Reset with start held high must not accept anything.
        #2;
        rst    = 1'b1;
        start  = 1'b1;
        startB = 1'b1;
        parIn  = 8'hFF;
        parInB = 5'h1F;
        #1;
        checkOutput("rstA", serOut, busy, done, {1'b0, 1'b0, 1'b0});
        checkOutput("rstB", serOutB, busyB, doneB, {1'b1, 1'b0, 1'b0});
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("rstHoldA", serOut, busy, done, {1'b0, 1'b0, 1'b0});
            checkOutput("rstHoldB", serOutB, busyB, doneB, {1'b1, 1'b0, 1'b0});
        end
        rst = 1'b0;

        // Frame A5 MSB first on A, 0F LSB first on B.
        applyStimulus(1'b1, 8'hA5, 1'b1, 5'h0F);
        gotA = serOut;
        gotB = {serOutB, 4'b0};
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0, 5'($urandom));
            gotA = {gotA[6:0], serOut};
            if (i < 5) gotB = {serOutB, gotB[4:1]};
        end
        checks++;
        assert (gotA === 8'hA5) else begin
            errors++;
            $error("[TB] FAIL streamA5 got=%h exp=a5", gotA);
        end
        checks++;
        assert (gotB === 5'h0F) else begin
            errors++;
            $error("[TB] FAIL streamB0F got=%h exp=0f", gotB);
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 5'h00);

        // Start during an in-flight all-zero frame is ignored.
        applyStimulus(1'b1, 8'h00, 1'b1, 5'h00);
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 5'h00);
        applyStimulus(1'b1, 8'hFF, 1'b1, 5'h1F);
        repeat (8) applyStimulus(1'b0, 8'hFF, 1'b0, 5'h1F);

        // Start held high: back-to-back frames, parIn changes at the done cycle.
        applyStimulus(1'b1, 8'hFF, 1'b1, 5'h15);
        repeat (8) applyStimulus(1'b1, 8'hFF, 1'b1, 5'h0A);
        applyStimulus(1'b1, 8'h81, 1'b1, 5'h13);
        repeat (9) applyStimulus(1'b1, 8'h3C, 1'b1, 5'h06);
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0, 5'h00);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0), 8'($urandom),
                          ($urandom_range(0, 2) == 0), 5'($urandom));
        end
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 5'h00);

        // Asynchronous reset in the middle of a frame aborts it.
        applyStimulus(1'b1, 8'hFF, 1'b1, 5'h1F);
        repeat (2) applyStimulus(1'b0, 8'hFF, 1'b0, 5'h1F);
        #3;
        rst    = 1'b1;
        start  = 1'b1;
        startB = 1'b1;
        #1;
        checkOutput("asyncRstA", serOut, busy, done, {1'b0, 1'b0, 1'b0});
        checkOutput("asyncRstB", serOutB, busyB, doneB, {1'b1, 1'b0, 1'b0});
        qA.delete();
        qB.delete();
        curA = {1'b0, 1'b0, 1'b0};
        curB = {1'b1, 1'b0, 1'b0};
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) applyStimulus(1'b0, 8'hFF, 1'b0, 5'h1F);
        applyStimulus(1'b1, 8'h5A, 1'b1, 5'h09);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 5'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_shifter.md
SERIAL_FRAME_SHIFTER -- requirements
Module: serial_frame_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per frame (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = transmit bit WIDTH-1 first and 0 = transmit bit 0 first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, meaning the serOut level when no frame is in flight.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: frame request, sampled on the rising edge of clk.
REQ-007 The block SHALL have port parIn, input, WIDTH bits: parallel frame data, sampled on the same edge as an accepted start.
REQ-008 The block SHALL have port serOut, output, 1 bit: serial stream, driving the downstream sequence detector's serIn.
REQ-009 The block SHALL have port busy, output, 1 bit: frame bits are being driven.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a frame.

Function
REQ-011 The block SHALL implement three states, IDLE, SHIFT and DONE, with serOut, busy and done all registered (no combinational path from any input to any output).
REQ-012 In IDLE: serOut=IDLE_BIT, busy=0, done=0; start=1 at an edge -> capture parIn into the shift register, clear the bit counter, next state SHIFT; start=0 -> remain in IDLE.
REQ-013 In SHIFT: busy=1; serOut carries frame bit k during the (k+1)th cycle after the accepting edge, k=0..WIDTH-1, in MSB_FIRST order.
REQ-014 Latency SHALL be exactly one cycle from the accepting edge to the first bit on serOut, with exactly WIDTH consecutive bit cycles and no gaps.
REQ-015 Counter SHALL be wide enough to count to WIDTH-1 without wrap; after bit WIDTH-1 the next state is DONE.
REQ-016 In DONE (exactly one cycle): done=1, busy=0, serOut=IDLE_BIT.
REQ-017 In DONE with start=1: accept a new frame (capture parIn) and go to SHIFT, giving exactly one IDLE_BIT cycle between frames.
REQ-018 In DONE with start=0: go to IDLE.
REQ-019 In SHIFT, start SHALL be ignored (no queuing, no restart), and changes on parIn SHALL NOT affect the in-flight frame.
REQ-020 When start is held continuously high, the block SHALL transmit back-to-back frames of period WIDTH+1 cycles, each capturing parIn at its accepting edge.
REQ-021 Bits SHALL be emitted exactly as captured, with no parity, framing or inversion added.

Reset
REQ-022 While rst=1, the block SHALL immediately (asynchronously) force state=IDLE, serOut=IDLE_BIT, busy=0, done=0, shift register=0 and counter=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse and no remaining bits emitted after reset release.
REQ-024 start=1 while rst=1 SHALL be ignored; the first accept occurs at the first rising edge with rst=0 and start=1.

Verification
REQ-025 Scenario: WIDTH=8, MSB_FIRST=1, parIn=8'hA5, start pulsed at edge 0 -> serOut=1,0,1,0,0,1,0,1 in cycles 1..8, busy=1 in cycles 1..8, done=1 only in cycle 9, then serOut=0.
REQ-026 Scenario: MSB_FIRST=0, parIn=8'hA5 -> serOut=1,0,1,0,0,1,0,1 reversed order, i.e. 1,0,1,0,0,1,0,1 read LSB first = 1,0,1,0,0,1,0,1; use 8'h0F instead: expect 1,1,1,1,0,0,0,0.
REQ-027 Scenario: start=1 again in cycle 4 with parIn=8'hFF during frame 8'h00 -> serOut stays 0 for all 8 bits, done in cycle 9, no second frame.
REQ-028 Scenario: start held high, parIn=8'hFF then 8'h81 at cycle 9 -> cycles 1..8 all 1, cycle 9 IDLE_BIT with done=1, cycles 10..17 = 1,0,0,0,0,0,0,1.
REQ-029 Scenario: rst pulsed asynchronously between edges during bit 3 of 8'hFF -> serOut falls to 0 and busy to 0 before the next edge, no done pulse, IDLE retained until a new start.
REQ-030 Scenario: frame 8'hFF into the downstream sequence detector with IDLE_BIT=0 -> its seqValid matches a reference model for the stream 0,1×8,0.
